rr_arbiter_param_slice: RTL and testbench

//  Parametrised round-robin arbiter for N requesters. Each grant lasts a per-requester time slice, set at runtime.

---
 rtl/rr_arbiter_param_slice_pkg.sv | 31 +++
 rtl/rr_arbiter_param_slice_if.sv | 31 +++
 rtl/rr_arbiter_param_slice_pick.sv | 51 +++++
 rtl/rr_arbiter_param_slice.sv | 131 +++++++++++++
 tb/tb_rr_arbiter_param_slice.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/rr_arbiter_param_slice_pkg.sv
// Shared types and helpers for the parametrised round-robin slice arbiter.
// Imported by the interface, the pick network and the top level.
package rr_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_e;

  // Reason for the most recent register update, exposed for debug.
  typedef enum logic [1:0] {
    DEC_HOLD    = 2'd0,
    DEC_GRANT   = 2'd1,
    DEC_RELEASE = 2'd2,
    DEC_EXPIRE  = 2'd3
  } arb_dec_e;

  localparam int SLICE_W_DEF = 4;
  typedef logic [SLICE_W_DEF-1:0] slice_def_t;

  // Width of an index into N requesters; never narrower than one bit.
  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Pointer reset value, so that requester 0 is searched first.
  function automatic int ptr_rst(input int n);
    return n - 1;
  endfunction

endpackage

// File: rtl/rr_arbiter_param_slice_if.sv
// Requester/arbiter bundle. REQ is a level held by each master until it is
// served or withdrawn; GNT acts as the ready for that request.
interface rr_arbiter_param_slice_if
  import rr_arb_pkg::*;
#(
  parameter int N       = 4,
  parameter int SLICE_W = 4
);
  localparam int IDX_W = clog2_safe(N);

  logic [N-1:0]         REQ;
  logic [N*SLICE_W-1:0] SLICE_LEN;
  logic [N-1:0]         GNT;
  logic [IDX_W-1:0]     GNT_ID;
  logic                 GNT_VLD;
  logic [SLICE_W-1:0]   SLICE_LEFT;
  logic                 SLICE_END;
  arb_state_e           dbg_state;
  arb_dec_e             dbg_dec;

  modport slave (
    input  REQ, SLICE_LEN,
    output GNT, GNT_ID, GNT_VLD, SLICE_LEFT, SLICE_END, dbg_state, dbg_dec
  );

  modport master (
    output REQ, SLICE_LEN,
    input  GNT, GNT_ID, GNT_VLD, SLICE_LEFT, SLICE_END, dbg_state, dbg_dec
  );

endinterface

// File: rtl/rr_arbiter_param_slice_pick.sv
// Round-robin pick: first set request after ptr, wrapping, optionally
// ignoring one index. Doubled vector rotate followed by a priority encode.
module rr_pick
  import rr_arb_pkg::*;
#(
  parameter  int N     = 4,
  localparam int IDX_W = clog2_safe(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             excl_en,
  input  logic [IDX_W-1:0] excl_idx,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [N-1:0]   req_m;
  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   req_rot;
  int             start;
  int             offset;
  int             sum;

  always_comb begin
    req_m = req;
    for (int i = 0; i < N; i++) begin
      if (excl_en && (excl_idx == IDX_W'(i))) req_m[i] = 1'b0;
    end

    start = int'(ptr) + 1;
    if (start >= N) start = 0;

    req_dbl = {req_m, req_m};
    req_rot = N'(req_dbl >> start);

    // Scan downwards so the lowest rotated position (closest to ptr) wins.
    found  = 1'b0;
    offset = 0;
    for (int j = N - 1; j >= 0; j--) begin
      if (req_rot[j]) begin
        found  = 1'b1;
        offset = j;
      end
    end

    sum = start + offset;
    if (sum >= N) sum = sum - N;
    idx = IDX_W'(sum);
  end

endmodule

// File: rtl/rr_arbiter_param_slice.sv
// Round-robin arbiter with per-requester runtime time slices, early release
// and gap-free handover. Holds the grant, pointer and slice counter.
module rr_arbiter_param_slice
  import rr_arb_pkg::*;
#(
  parameter int N       = 4,
  parameter int SLICE_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  rr_arbiter_param_slice_if.slave bus
);

  localparam int IDX_W = clog2_safe(N);

  typedef logic [SLICE_W-1:0] slice_t;
  typedef logic [IDX_W-1:0]   idx_t;

  localparam idx_t   PTR_RST   = idx_t'(ptr_rst(N));
  localparam slice_t SLICE_ONE = slice_t'(1);

  arb_state_e   state_q, state_d;
  arb_dec_e     dec_q, dec_d;
  logic [N-1:0] gnt_q, gnt_d;
  idx_t         gnt_id_q, gnt_id_d;
  idx_t         ptr_q, ptr_d;
  slice_t       slice_left_q, slice_left_d;

  logic   req_own;
  logic   own_expiring;
  logic   excl_en;
  logic   pick_found;
  idx_t   pick_idx;
  slice_t pick_len;
  logic   do_grant;

  assign req_own      = bus.REQ[gnt_id_q];
  assign own_expiring = (slice_left_q == SLICE_ONE);
  // Only an owner that has dropped its request is kept out of the re-pick.
  assign excl_en      = (state_q == ST_OWN) && !req_own;

  rr_pick #(.N(N)) u_pick (
    .req      (bus.REQ),
    .ptr      (ptr_q),
    .excl_en  (excl_en),
    .excl_idx (gnt_id_q),
    .found    (pick_found),
    .idx      (pick_idx)
  );

  assign pick_len = bus.SLICE_LEN[int'(pick_idx)*SLICE_W +: SLICE_W];

  always_comb begin
    state_d      = state_q;
    dec_d        = DEC_HOLD;
    gnt_d        = gnt_q;
    gnt_id_d     = gnt_id_q;
    ptr_d        = ptr_q;
    slice_left_d = slice_left_q;
    do_grant     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          do_grant = 1'b1;
          dec_d    = DEC_GRANT;
        end
      end
      ST_OWN: begin
        if (!req_own) begin
          dec_d = DEC_RELEASE;
          if (pick_found) begin
            do_grant = 1'b1;
          end else begin
            state_d      = ST_IDLE;
            gnt_d        = '0;
            gnt_id_d     = '0;
            slice_left_d = '0;
          end
        end else if (own_expiring) begin
          // The owner still requests, so the pick always finds someone,
          // falling back to the owner itself when nobody else is waiting.
          dec_d    = DEC_EXPIRE;
          do_grant = 1'b1;
        end else begin
          slice_left_d = slice_left_q - SLICE_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (do_grant) begin
      state_d         = ST_OWN;
      gnt_d           = '0;
      gnt_d[pick_idx] = 1'b1;
      gnt_id_d        = pick_idx;
      ptr_d           = pick_idx;
      slice_left_d    = (pick_len == '0) ? SLICE_ONE : pick_len;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      dec_q        <= DEC_HOLD;
      gnt_q        <= '0;
      gnt_id_q     <= '0;
      ptr_q        <= PTR_RST;
      slice_left_q <= '0;
    end else begin
      state_q      <= state_d;
      dec_q        <= dec_d;
      gnt_q        <= gnt_d;
      gnt_id_q     <= gnt_id_d;
      ptr_q        <= ptr_d;
      slice_left_q <= slice_left_d;
    end
  end

  assign bus.GNT        = gnt_q;
  assign bus.GNT_ID     = gnt_id_q;
  assign bus.GNT_VLD    = (state_q == ST_OWN);
  assign bus.SLICE_LEFT = slice_left_q;
  // Live owner request: an owner that lets go in its last cycle gets no pulse.
  assign bus.SLICE_END  = (state_q == ST_OWN) && own_expiring && req_own;
  assign bus.dbg_state  = state_q;
  assign bus.dbg_dec    = dec_q;

endmodule

// File: tb/tb_rr_arbiter_param_slice.sv
// Directed bench for rr_arbiter_param_slice (N=4, SLICE_W=4, 10 ns clock),
// plus a short random run with per-cycle invariants.
module tb_rr_arbiter_param_slice;
  import rr_arb_pkg::*;

  localparam int N       = 4;
  localparam int SLICE_W = 4;
  localparam int W       = 32;
  localparam int STARVE  = N * ((1 << SLICE_W) - 1);

  logic clk;
  logic rst_n;

  rr_arbiter_param_slice_if #(.N(N), .SLICE_W(SLICE_W)) bus ();

  rr_arbiter_param_slice #(.N(N), .SLICE_W(SLICE_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_bad;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic apply_reset();
    rst_n         = 1'b0;
    bus.REQ       = '0;
    bus.SLICE_LEN = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_gnt"},   W'(bus.GNT), 0);
    check({tag, "_vld"},   W'(bus.GNT_VLD), 0);
    check({tag, "_id"},    W'(bus.GNT_ID), 0);
    check({tag, "_left"},  W'(bus.SLICE_LEFT), 0);
    check({tag, "_end"},   W'(bus.SLICE_END), 0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [N-1:0] req, input logic [N*SLICE_W-1:0] len);
    bus.REQ       = req;
    bus.SLICE_LEN = len;
  endtask

  // Check grant, derived id and slice counter against one expected owner.
  task automatic check_own(input string tag, input int owner, input int left, input int send);
    check({tag, "_gnt"},  W'(bus.GNT), W'(1 << owner));
    check({tag, "_id"},   W'(bus.GNT_ID), W'(owner));
    check({tag, "_vld"},  W'(bus.GNT_VLD), 1);
    check({tag, "_left"}, W'(bus.SLICE_LEFT), W'(left));
    check({tag, "_end"},  W'(bus.SLICE_END), W'(send));
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    bus.REQ = '0;
    bus.SLICE_LEN = '0;
    #1;
    check_idle("rst_async");
    check("rst_state", W'(bus.dbg_state), W'(ST_IDLE));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_idle("rst_idle");
    end
    drive(4'b0100, {4'd3, 4'd5, 4'd2, 4'd1});
    @(negedge clk);
    check_own("rst_pre", 2, 5, 0);
    #2 rst_n = 1'b0;
    #1;
    check_idle("rst_mid");
  endtask

  task automatic test_rotation();
    int own_tab[10]  = '{0, 0, 0, 0, 1, 2, 2, 3, 3, 3};
    int left_tab[10] = '{4, 3, 2, 1, 1, 2, 1, 3, 2, 1};
    int end_tab[10]  = '{0, 0, 0, 1, 1, 0, 1, 0, 0, 1};
    apply_reset();
    drive(4'b1111, {4'd3, 4'd2, 4'd1, 4'd4});
    for (int c = 0; c < 20; c++) exp_q.push_back(W'(own_tab[c % 10]));
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check_own("rot", int'(exp_q.pop_front()), left_tab[c % 10], end_tab[c % 10]);
    end
  endtask

  task automatic test_single();
    apply_reset();
    drive(4'b0010, {4'd7, 4'd7, 4'd2, 4'd7});
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check_own("solo", 1, (c % 2 == 0) ? 2 : 1, (c % 2 == 0) ? 0 : 1);
    end
  endtask

  task automatic test_early_release();
    apply_reset();
    drive(4'b1100, {4'd5, 4'd8, 4'd1, 4'd1});
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_own("erl_own", 2, 8 - c, 0);
    end
    bus.REQ = 4'b1000;
    #1;
    check("erl_noend", W'(bus.SLICE_END), 0);
    @(negedge clk);
    check_own("erl_new", 3, 5, 0);
    check("erl_dec", W'(bus.dbg_dec), W'(DEC_RELEASE));
  endtask

  task automatic test_zero_len();
    apply_reset();
    drive(4'b1111, '0);
    for (int c = 0; c < 5; c++) exp_q.push_back(W'(c % N));
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_own("zero", int'(exp_q.pop_front()), 1, 1);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] req_prev;
    int wait_cnt[N];
    int max_wait;
    apply_reset();
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    req_prev = '0;
    for (int c = 0; c < 600; c++) begin
      logic [N-1:0] r;
      r = bus.REQ;
      for (int i = 0; i < N; i++) begin
        if (r[i]) r[i] = ($urandom_range(7, 0) != 0);
        else      r[i] = ($urandom_range(1, 0) != 0);
      end
      drive(r, (N*SLICE_W)'({$urandom, $urandom}));
      req_prev = r;
      @(negedge clk);
      check("rnd_onehot", W'($countones(bus.GNT) <= 1), 1);
      check("rnd_id", W'(bus.GNT), bus.GNT_VLD ? W'(1 << bus.GNT_ID) : 0);
      check("rnd_idle_gnt", W'(bus.GNT & ~req_prev), 0);
      max_wait = 0;
      for (int i = 0; i < N; i++) begin
        if (req_prev[i] && !bus.GNT[i]) wait_cnt[i]++;
        else                            wait_cnt[i] = 0;
        if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
      end
      check("rnd_starve", W'(max_wait <= STARVE), 1);
    end
  endtask

  // ---------------- main + report ----------------
  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.REQ = '0;
    bus.SLICE_LEN = '0;
    @(negedge clk);
    test_reset();
    test_rotation();
    test_single();
    test_early_release();
    test_zero_len();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
